// File: rtl/host_cmd_tx.sv
// host_cmd_tx: buffers 32-bit host commands in a FIFO and sends each one as two 16-bit stream beats, low half first;
// separately acknowledges irq_req after a programmable delay and counts the acknowledges.
module host_cmd_tx #(
   parameter int FIFO_DEPTH  = 8,
   parameter int IRQ_ACK_DLY = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [31:0]                 i_cmd_data,
   input  logic                        i_cmd_last,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   output logic [15:0]                 o_m_axis_tdata,
   output logic                        o_m_axis_tvalid,
   input  logic                        i_m_axis_tready,
   output logic                        o_m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
   output logic                        o_tx_busy,
   input  logic                        i_irq_req,
   output logic                        o_irq_ack,
   output logic [7:0]                  o_irq_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(IRQ_ACK_DLY) + 1;
   typedef enum logic [1:0] {IDLE, LO, HI} tx_state_t;
   typedef enum logic [1:0] {I_IDLE, I_WAIT, I_ACK, I_HOLD} irq_state_t;
   tx_state_t     r_tx_state;
   irq_state_t    r_irq_state;
   logic [32:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_level;
   logic [32:0]   r_word;
   logic [CW-1:0] r_dly;
   logic [7:0]    r_irq_count;
   logic          w_push, w_pop, w_empty;
   assign w_empty = r_level == '0;
   assign o_cmd_ready = r_level != (AW+1)'(FIFO_DEPTH);
   assign w_push = i_cmd_valid && o_cmd_ready;
   // Refill straight from HI so back-to-back commands stream without a bubble
   assign w_pop = !w_empty && (r_tx_state == IDLE || (r_tx_state == HI && i_m_axis_tready));
   assign o_m_axis_tvalid = r_tx_state != IDLE;
   assign o_m_axis_tdata = r_tx_state == HI ? r_word[31:16] : r_word[15:0];
   assign o_m_axis_tlast = r_tx_state == HI && r_word[32];
   assign o_tx_busy = !w_empty || r_tx_state != IDLE;
   assign o_fifo_level = r_level;
   assign o_irq_ack = r_irq_state == I_ACK;
   assign o_irq_count = r_irq_count;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_last, i_cmd_data};
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push != w_pop) r_level <= w_push ? r_level + 1'b1 : r_level - 1'b1;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_state <= IDLE;
         r_word <= '0;
      end else begin
         if (w_pop) r_word <= r_mem[r_rd_ptr];
         case (r_tx_state)
            IDLE:    if (!w_empty) r_tx_state <= LO;
            LO:      if (i_m_axis_tready) r_tx_state <= HI;
            HI:      if (i_m_axis_tready) r_tx_state <= w_empty ? IDLE : LO;
            default: r_tx_state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_irq_state <= I_IDLE;
         r_dly <= '0;
         r_irq_count <= '0;
      end else begin
         case (r_irq_state)
            I_IDLE: if (i_irq_req) begin
               r_dly <= CW'(IRQ_ACK_DLY - 1);
               r_irq_state <= I_WAIT;
            end
            I_WAIT: begin
               if (!i_irq_req) r_irq_state <= I_IDLE;
               else if (r_dly == '0) r_irq_state <= I_ACK;
               else r_dly <= r_dly - 1'b1;
            end
            I_ACK: begin
               if (r_irq_count != 8'hFF) r_irq_count <= r_irq_count + 1'b1;
               r_irq_state <= I_HOLD;
            end
            I_HOLD:  if (!i_irq_req) r_irq_state <= I_IDLE;
            default: r_irq_state <= I_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_host_cmd_tx.sv
// tb_host_cmd_tx: checks host_cmd_tx using a table of commands with their expected beats,
// a queue of pending beats checked at each handshake, and hand-written multi-cycle sequences.
module tb_host_cmd_tx;
   logic        clk = 0, rst_n = 0;
   logic [31:0] cmd_data = '0;
   logic        cmd_last = 0, cmd_valid = 0, cmd_ready;
   logic [15:0] tdata;
   logic        tvalid, tready = 0, tlast;
   logic [3:0]  level;
   logic        busy, irq_req = 0, irq_ack;
   logic [7:0]  irq_count;
   int          total = 0, bad = 0, acks = 0, hs = 0, cyc = 0, first_hs = -1, last_hs = -1;
   logic [16:0] sb [$];
   typedef struct {logic [31:0] data; logic last; logic [15:0] lo; logic [15:0] hi; logic el;} vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   host_cmd_tx dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_data(cmd_data), .i_cmd_last(cmd_last), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .o_m_axis_tdata(tdata), .o_m_axis_tvalid(tvalid), .i_m_axis_tready(tready), .o_m_axis_tlast(tlast),
      .o_fifo_level(level), .o_tx_busy(busy),
      .i_irq_req(irq_req), .o_irq_ack(irq_ack), .o_irq_count(irq_count)
   );

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (irq_ack) acks++;
      if (rst_n && tvalid && tready) begin
         hs++;
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got %0h expected no beat", {tdata, tlast});
         end else check("beat", 32'({tdata, tlast}), 32'(sb.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      cmd_valid = 0;
      tready = 0;
      irq_req = 0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic send(input logic [31:0] d, input logic l, input logic [15:0] elo, input logic [15:0] ehi, input logic el);
      int n = 0;
      cmd_data = d;
      cmd_last = l;
      cmd_valid = 1;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got cmd_ready=0 expected 1 within 100 cycles");
      end else begin
         sb.push_back({elo, 1'b0});
         sb.push_back({ehi, el});
      end
      @(posedge clk);
      #1 cmd_valid = 0;
   endtask

   task automatic drain(string name);
      int n = 0;
      tready = 1;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check({name, "_drained"}, 32'(busy), 0);
      check({name, "_sb_empty"}, 32'(sb.size()), 0);
   endtask

   task automatic irq_pulse();
      irq_req = 1;
      repeat (4) tick();
      irq_req = 0;
      repeat (2) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1 ms");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h12345678, 1'b0, 16'h5678, 16'h1234, 1'b0};
      vecs[1] = '{32'h0000FFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
      vecs[2] = '{32'hFFFF0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
      vecs[3] = '{32'hA5A55A5A, 1'b1, 16'h5A5A, 16'hA5A5, 1'b1};
      vecs[4] = '{32'h80000001, 1'b1, 16'h0001, 16'h8000, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_tvalid", 32'(tvalid), 0);
      check("rst_tdata", 32'(tdata), 0);
      check("rst_tlast", 32'(tlast), 0);
      check("rst_level", 32'(level), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_irq_ack", 32'(irq_ack), 0);
      check("rst_irq_count", 32'(irq_count), 0);
      rst_n = 1;

      tready = 1;
      send(32'hDEADBEEF, 1'b1, 16'hBEEF, 16'hDEAD, 1'b1);
      check("t1_level_e0", 32'(level), 1);
      check("t1_tvalid_e0", 32'(tvalid), 0);
      tick();
      check("t1_tvalid_b0", 32'(tvalid), 1);
      check("t1_tdata_b0", 32'(tdata), 32'hBEEF);
      check("t1_tlast_b0", 32'(tlast), 0);
      tick();
      check("t1_tvalid_b1", 32'(tvalid), 1);
      check("t1_tdata_b1", 32'(tdata), 32'hDEAD);
      check("t1_tlast_b1", 32'(tlast), 1);
      tick();
      check("t1_tvalid_end", 32'(tvalid), 0);
      check("t1_busy_end", 32'(busy), 0);

      foreach (vecs[i]) begin
         send(vecs[i].data, vecs[i].last, vecs[i].lo, vecs[i].hi, vecs[i].el);
         drain("vec");
      end

      do_reset();
      send(32'hDEADBEEF, 1'b1, 16'hBEEF, 16'hDEAD, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_tdata", 32'(tdata), 32'hBEEF);
         check("t2_hold_tvalid", 32'(tvalid), 1);
         tick();
      end
      drain("t2");

      do_reset();
      for (int i = 0; i < 9; i++)
         send({16'(16'hA000 + i), 16'(16'hB000 + i)}, 1'b0, 16'(16'hB000 + i), 16'(16'hA000 + i), 1'b0);
      check("t3_full_level", 32'(level), 8);
      check("t3_full_ready", 32'(cmd_ready), 0);
      cmd_data = 32'h0BADF00D;
      cmd_valid = 1;
      tick();
      cmd_valid = 0;
      check("t3_no_push_level", 32'(level), 8);
      tready = 1;
      tick();
      check("t3_pop_cycle_level", 32'(level), 8);
      check("t3_pop_cycle_ready", 32'(cmd_ready), 0);
      tick();
      check("t3_after_pop_level", 32'(level), 7);
      check("t3_after_pop_ready", 32'(cmd_ready), 1);
      drain("t3");

      do_reset();
      tready = 1;
      hs = 0;
      first_hs = -1;
      send(32'h00020001, 1'b0, 16'h0001, 16'h0002, 1'b0);
      send(32'h00040003, 1'b0, 16'h0003, 16'h0004, 1'b0);
      send(32'h00060005, 1'b1, 16'h0005, 16'h0006, 1'b1);
      drain("t4");
      check("t4_beats", 32'(hs), 6);
      check("t4_contiguous", 32'(last_hs - first_hs), 5);

      do_reset();
      acks = 0;
      irq_req = 1;
      repeat (10) tick();
      irq_req = 0;
      repeat (3) tick();
      check("t5_hold_acks", 32'(acks), 1);
      check("t5_hold_count", 32'(irq_count), 1);
      irq_req = 1;
      tick();
      irq_req = 0;
      repeat (4) tick();
      check("t5_short_acks", 32'(acks), 1);
      check("t5_short_count", 32'(irq_count), 1);
      for (int i = 0; i < 254; i++) irq_pulse();
      check("t5_count_255", 32'(irq_count), 255);
      irq_pulse();
      check("t5_sat_count", 32'(irq_count), 255);
      check("t5_sat_acks", 32'(acks), 256);

      do_reset();
      tready = 1;
      send(32'hDEADBEEF, 1'b1, 16'hBEEF, 16'hDEAD, 1'b1);
      send(32'h11112222, 1'b0, 16'h2222, 16'h1111, 1'b0);
      tick();
      check("t6_hi_tvalid", 32'(tvalid), 1);
      check("t6_hi_tdata", 32'(tdata), 32'hDEAD);
      check("t6_hi_level", 32'(level), 1);
      #2 rst_n = 0;
      sb.delete();
      #1;
      check("t6_async_tvalid", 32'(tvalid), 0);
      check("t6_async_level", 32'(level), 0);
      @(posedge clk);
      #1 rst_n = 1;
      repeat (6) tick();
      check("t6_post_tvalid", 32'(tvalid), 0);
      check("t6_post_ready", 32'(cmd_ready), 1);
      check("t6_post_busy", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
